// File: rtl/batch_drain_scheduler_pkg.sv
// Shared definitions for the batch drain path: scheduler state encoding and
// the default batch-size width / read latency also used by the batch FIFO and
// permuter wrappers. No ports; import with batch_drain_scheduler_pkg::*.
package batch_drain_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLOSE = 2'd2
    } sched_state_e;

    localparam int BDS_SIZE_W       = 6;
    localparam int BDS_READ_LATENCY = 4;

endpackage

// File: rtl/hyperpipe.sv
// Purpose : plain retiming delay line, DEPTH register stages (DEPTH >= 1).
// Latency : exactly DEPTH cycles from d_i to q_o.
// Backpr. : none; free-running, synchronous active-high reset clears all stages.
// Ports   : clk, rst, d_i[WIDTH], q_o[WIDTH].
module hyperpipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/rr_grant_picker.sv
// Purpose : round-robin pick of the first set request after last_grant_i.
// Latency : combinational.
// Backpr. : none; found_o low when no request is set.
// Ports   : req_i[NUM_REQ], last_grant_i[IDX_W] -> grant_o[IDX_W], found_o.
module rr_grant_picker
    import batch_drain_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               found_o
);

    logic [IDX_W-1:0] cand;

    // Walk last+1 .. last+NUM_REQ (mod NUM_REQ); the last step revisits
    // last_grant_i itself so a lone requester can be granted repeatedly.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                grant_o = cand;
            end
        end
    end

endmodule

// File: rtl/batch_drain_scheduler.sv
// Purpose : grants one batch requester round-robin, drains its batch one read per
//           cycle into the shared permuter, then emits one end-of-batch marker.
// Latency : accept/readReq are registered (1 cycle after the deciding edge);
//           dataArrives/batchDoneArrives follow readReq/close by READ_LATENCY.
// Backpr. : slowDown high blocks new grants and holds the drain (no readReq).
// Ports   : clk, rst (sync, active-high); batchValid/batchSizes in,
//           batchAccept/readReq one-hot out; dataArrives, batchDoneArrives,
//           activeIdx, busy; statBatches/statItems/statStalls counters, live
//           only when BATCH_SCHED_STATS_EN is defined, otherwise tied to 0.
module batch_drain_scheduler
    import batch_drain_scheduler_pkg::*;
#(
    parameter int  NUM_REQ      = 8,
    parameter int  SIZE_W       = BDS_SIZE_W,
    parameter int  READ_LATENCY = BDS_READ_LATENCY,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        batchValid,
    input  logic [NUM_REQ*SIZE_W-1:0] batchSizes,
    output logic [NUM_REQ-1:0]        batchAccept,
    input  logic                      slowDown,
    output logic [NUM_REQ-1:0]        readReq,
    output logic                      dataArrives,
    output logic                      batchDoneArrives,
    output logic [IDX_W-1:0]          activeIdx,
    output logic                      busy,
    output logic [31:0]               statBatches,
    output logic [31:0]               statItems,
    output logic [31:0]               statStalls
);

    sched_state_e        state_q;
    logic [SIZE_W-1:0]   remaining_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [IDX_W-1:0]    active_idx_q;
    logic [NUM_REQ-1:0]  accept_q;
    logic [NUM_REQ-1:0]  read_req_q;
    logic                done_q;

    logic [IDX_W-1:0]    grant_idx;
    logic                grant_found;
    logic [SIZE_W-1:0]   grant_size;

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i        (batchValid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_idx),
        .found_o      (grant_found)
    );

    assign grant_size = batchSizes[SIZE_W*grant_idx +: SIZE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            active_idx_q <= '0;
            accept_q     <= '0;
            read_req_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            accept_q   <= '0;
            read_req_q <= '0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_found && !slowDown) begin
                        accept_q     <= NUM_REQ'(1) << grant_idx;
                        remaining_q  <= grant_size;
                        active_idx_q <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= (grant_size != '0) ? DRAIN : CLOSE;
                    end
                end
                DRAIN: begin
                    // DRAIN is only entered with remaining_q > 0 and left on the
                    // read that takes it to 0, so the decrement cannot wrap.
                    if (!slowDown) begin
                        read_req_q  <= NUM_REQ'(1) << active_idx_q;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == SIZE_W'(1)) state_q <= CLOSE;
                    end
                end
                CLOSE: begin
                    // Marker enters the pipe one cycle after the last read, so
                    // it always trails that batch's data by exactly one slot.
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign batchAccept = accept_q;
    assign readReq     = read_req_q;
    assign activeIdx   = active_idx_q;
    assign busy        = (state_q != IDLE);

    hyperpipe #(
        .WIDTH (1),
        .DEPTH (READ_LATENCY)
    ) u_data_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (|read_req_q),
        .q_o (dataArrives)
    );

    hyperpipe #(
        .WIDTH (1),
        .DEPTH (READ_LATENCY)
    ) u_done_pipe (
        .clk (clk),
        .rst (rst),
        .d_i (done_q),
        .q_o (batchDoneArrives)
    );

`ifdef BATCH_SCHED_STATS_EN
    logic [31:0] stat_batches_q;
    logic [31:0] stat_items_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_batches_q <= '0;
            stat_items_q   <= '0;
            stat_stalls_q  <= '0;
        end else begin
            if (state_q == CLOSE && stat_batches_q != '1)
                stat_batches_q <= stat_batches_q + 32'd1;
            if (state_q == DRAIN && !slowDown && stat_items_q != '1)
                stat_items_q <= stat_items_q + 32'd1;
            if (state_q == DRAIN && slowDown && stat_stalls_q != '1)
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign statBatches = stat_batches_q;
    assign statItems   = stat_items_q;
    assign statStalls  = stat_stalls_q;
`else
    assign statBatches = '0;
    assign statItems   = '0;
    assign statStalls  = '0;
`endif

endmodule

// File: tb/tb_batch_drain_scheduler.sv
// Purpose : self-checking bench for batch_drain_scheduler against a
//           transaction-level reference (grant order, read slots, arrival times).
// Latency : n/a.  Backpr.: drives slowDown directly.
module tb_batch_drain_scheduler;

    localparam int N  = 8;
    localparam int SW = 6;
    localparam int RL = 4;
    localparam int IW = 3;
`ifdef BATCH_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    batchValid = '0;
    logic [N*SW-1:0] batchSizes = '0;
    logic            slowDown = 1'b0;
    logic [N-1:0]    batchAccept;
    logic [N-1:0]    readReq;
    logic            dataArrives;
    logic            batchDoneArrives;
    logic [IW-1:0]   activeIdx;
    logic            busy;
    logic [31:0]     statBatches, statItems, statStalls;

    always #5 clk = ~clk;

    batch_drain_scheduler #(
        .NUM_REQ      (N),
        .SIZE_W       (SW),
        .READ_LATENCY (RL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .batchValid       (batchValid),
        .batchSizes       (batchSizes),
        .batchAccept      (batchAccept),
        .slowDown         (slowDown),
        .readReq          (readReq),
        .dataArrives      (dataArrives),
        .batchDoneArrives (batchDoneArrives),
        .activeIdx        (activeIdx),
        .busy             (busy),
        .statBatches      (statBatches),
        .statItems        (statItems),
        .statStalls       (statStalls)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Requester side: a pending descriptor per lane, held until accepted.
    logic [N-1:0]  pend = '0;
    logic [SW-1:0] psize [N];

    // Inputs as seen by the edge that produced the outputs being checked.
    bit            prev_rst, prev_slow;
    logic [N-1:0]  prev_valid;
    int            prev_size [N];

    // Reference: current batch, earliest decision cycle, arrival timetables.
    int m_last, m_act, m_left, m_free, m_batches, m_items, m_stalls;
    bit m_inb;
    int data_q[$];
    int done_q[$];

    logic [N-1:0] obs_acc, obs_rd;
    logic         obs_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic close_batch();
        m_free = cyc + 1;
        done_q.push_back(cyc + 1 + RL);
        m_batches++;
    endtask

    task automatic model_and_check();
        logic [N-1:0] exp_acc;
        logic [N-1:0] exp_rd;
        bit exp_data, exp_done;
        int g;
        exp_acc = '0;
        exp_rd  = '0;
        if (prev_rst) begin
            m_last = N - 1; m_act = 0; m_inb = 0; m_left = 0; m_free = cyc;
            m_batches = 0; m_items = 0; m_stalls = 0;
            data_q.delete();
            done_q.delete();
        end else if (m_inb) begin
            if (prev_slow) begin
                m_stalls++;
            end else begin
                exp_rd[m_act] = 1'b1;
                m_items++;
                data_q.push_back(cyc + RL);
                m_left--;
                if (m_left == 0) begin
                    m_inb = 0;
                    close_batch();
                end
            end
        end else if (cyc - 1 >= m_free && !prev_slow && prev_valid != '0) begin
            g = rr_pick(prev_valid, m_last);
            exp_acc[g] = 1'b1;
            m_last = g;
            m_act  = g;
            m_left = prev_size[g];
            if (m_left == 0) close_batch();
            else m_inb = 1;
        end
        exp_data = (data_q.size() > 0 && data_q[0] == cyc);
        if (exp_data) void'(data_q.pop_front());
        exp_done = (done_q.size() > 0 && done_q[0] == cyc);
        if (exp_done) void'(done_q.pop_front());

        chk("batchAccept", 32'(batchAccept), 32'(exp_acc));
        chk("readReq", 32'(readReq), 32'(exp_rd));
        chk("dataArrives", 32'(dataArrives), 32'(exp_data));
        chk("batchDoneArrives", 32'(batchDoneArrives), 32'(exp_done));
        chk("busy", 32'(busy), 32'(m_inb || cyc < m_free));
        chk("activeIdx", 32'(activeIdx), 32'(m_act));
    endtask

    task automatic step();
        batchValid = pend;
        for (int i = 0; i < N; i++) begin
            batchSizes[SW*i +: SW] = psize[i];
            prev_size[i] = int'(psize[i]);
        end
        prev_valid = pend;
        prev_rst   = rst;
        prev_slow  = slowDown;
        @(posedge clk);
        #1;
        cyc++;
        model_and_check();
        obs_acc  = batchAccept;
        obs_rd   = readReq;
        obs_done = batchDoneArrives;
        pend = pend & ~batchAccept;
    endtask

    task automatic do_reset();
        pend = '0;
        slowDown = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_statBatches"}, statBatches, STATS ? 32'(m_batches) : 32'd0);
        chk({tag, "_statItems"}, statItems, STATS ? 32'(m_items) : 32'd0);
        chk({tag, "_statStalls"}, statStalls, STATS ? 32'(m_stalls) : 32'd0);
    endtask

    initial begin
        bit got;
        int acc_cyc, done_cyc, nrd;
        for (int i = 0; i < N; i++) psize[i] = '0;

        // Single batch of 3 on lane 0.
        do_reset();
        pend[0] = 1'b1; psize[0] = 6'd3;
        for (int k = 0; k < 20; k++) step();
        chk("A_statItems_abs", statItems, STATS ? 32'd3 : 32'd0);
        chk_stats("A");

        // All lanes, size 1, re-armed: 0..7 then wrap.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin pend[i] = 1'b1; psize[i] = 6'd1; end
            end
            step();
        end
        pend = '0;
        for (int k = 0; k < 12; k++) step();
        chk_stats("B");

        // Empty batch on lane 5: marker only, RL+1 after accept.
        do_reset();
        pend[5] = 1'b1; psize[5] = 6'd0;
        acc_cyc = -1; done_cyc = -1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (obs_acc[5]) acc_cyc = cyc;
            if (obs_done && done_cyc < 0) done_cyc = cyc;
        end
        chk("C_accept_seen", 32'(acc_cyc >= 0), 32'd1);
        chk("C_done_offset", 32'(done_cyc - acc_cyc), 32'(RL + 1));

        // Size 4 with a two-cycle stall after the first read.
        do_reset();
        pend[1] = 1'b1; psize[1] = 6'd4;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (obs_acc[1]) got = 1;
        end
        chk("D_accept_wait", 32'(got), 32'd1);
        step();
        slowDown = 1'b1; step(); step();
        slowDown = 1'b0;
        for (int k = 0; k < 15; k++) step();
        chk("D_statStalls_abs", statStalls, STATS ? 32'd2 : 32'd0);
        chk_stats("D");

        // Maximum size: 63 reads, one marker.
        do_reset();
        pend[7] = 1'b1; psize[7] = 6'd63;
        for (int k = 0; k < 80; k++) step();
        chk("E_statItems_abs", statItems, STATS ? 32'd63 : 32'd0);
        chk_stats("E");

        // Reset after 2 of 5 reads; next grant must be lane 0.
        do_reset();
        pend[2] = 1'b1; psize[2] = 6'd5;
        nrd = 0;
        for (int k = 0; k < 20 && nrd < 2; k++) begin
            step();
            if (obs_rd[2]) nrd++;
        end
        chk("F_two_reads", 32'(nrd), 32'd2);
        rst = 1'b1; step(); step();
        pend[2] = 1'b1; psize[2] = 6'd5;
        pend[0] = 1'b1; psize[0] = 6'd1;
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (obs_acc != '0) begin
                got = 1;
                chk("F_grant_after_rst", 32'(obs_acc), 32'h1);
            end
        end
        chk("F_grant_wait", 32'(got), 32'd1);
        pend = '0;
        for (int k = 0; k < 20; k++) step();

        // Randomized traffic with stalls, withdrawals and occasional reset.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pend[i] = 1'b1;
                    psize[i] = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(0, 63))
                                                           : SW'($urandom_range(0, 4));
                end else if (pend[i] && $urandom_range(0, 39) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            slowDown = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; pend = '0; slowDown = 1'b0;
        for (int k = 0; k < 100; k++) step();
        chk_stats("R");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/batch_drain_scheduler.md
BATCH_DRAIN_SCHEDULER -- requirements
Module: batch_drain_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 8, giving the number of batch requesters (permutator lanes).
REQ-002 The block SHALL have parameter SIZE_W, default 6, giving the batch-size field width.
REQ-003 The block SHALL have parameter READ_LATENCY, default 4, giving the cycles from read strobe to data at the shared permuter input.
REQ-004 The block SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port batchValid, input, NUM_REQ; requester i offers one batch descriptor.
REQ-007 The block SHALL have port batchSizes, input, NUM_REQ*SIZE_W; the size of requester i's batch is in slice [SIZE_W*i +: SIZE_W].
REQ-008 The block SHALL have port batchAccept, output, NUM_REQ; one-hot pulse that consumes the descriptor.
REQ-009 The block SHALL have port slowDown, input, 1; downstream almost-full.
REQ-010 The block SHALL have port readReq, output, NUM_REQ; one-hot read strobe to the selected batch memory.
REQ-011 The block SHALL have port dataArrives, output, 1; readReq OR-reduced, delayed READ_LATENCY cycles.
REQ-012 The block SHALL have port batchDoneArrives, output, 1; end-of-batch marker, aligned with data timing.
REQ-013 The block SHALL have port activeIdx, output, clog2(NUM_REQ); index of the requester currently draining.
REQ-014 The block SHALL have port busy, output, 1; high when the state is not IDLE.
REQ-015 The block SHALL have ports statBatches, statItems and statStalls, output, 32 each; performance counters.

Function
REQ-016 The block SHALL implement states IDLE, DRAIN and CLOSE.
REQ-017 In IDLE, when any batchValid bit is set and slowDown is low, the block SHALL grant round-robin, starting the search at (lastGrant+1) mod NUM_REQ. It SHALL pulse batchAccept[g] for 1 cycle, load remaining<=size, and record g in activeIdx and lastGrant.
REQ-018 After a grant, the block SHALL enter DRAIN if size>0, otherwise CLOSE.
REQ-019 In DRAIN, each cycle with slowDown low, the block SHALL assert readReq[activeIdx] and decrement remaining. The cycle that reaches remaining==0 SHALL move to CLOSE.
REQ-020 In DRAIN, while slowDown is high, readReq SHALL be 0 and remaining SHALL hold.
REQ-021 In CLOSE, the block SHALL issue one end marker into the delay pipe, then go to IDLE. Back-to-back grants therefore have a minimum gap of 1 cycle.
REQ-022 batchDoneArrives SHALL fire exactly READ_LATENCY cycles after the CLOSE cycle. It SHALL never coincide with a dataArrives pulse of the same batch and SHALL follow all of that batch's data.
REQ-023 Descriptors whose batchValid bit drops before grant SHALL be ignored. The block SHALL never assert batchAccept on a low batchValid bit.
REQ-024 At most one bit of batchAccept and at most one bit of readReq SHALL be high in any cycle.
REQ-025 The remaining counter SHALL be SIZE_W bits wide, with no wrap below 0. A size of all-ones SHALL yield exactly 2^SIZE_W-1 reads.
REQ-026 lastGrant SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-027 Reset SHALL force state IDLE, remaining 0, lastGrant NUM_REQ-1 (so the first grant goes to index 0), and activeIdx 0.
REQ-028 Reset SHALL clear both delay pipes and all counters.
REQ-029 During reset and in the cycle after it, batchAccept, readReq, dataArrives, batchDoneArrives and busy SHALL all be 0.
REQ-030 Reset asserted mid-batch SHALL abandon that batch: no further readReq and no end marker.

Configuration
REQ-031 With BATCH_SCHED_STATS_EN defined, the block SHALL maintain three counters:
- statBatches: +1 per CLOSE.
- statItems: +1 per readReq cycle.
- statStalls: +1 per DRAIN cycle with slowDown high.
All three SHALL saturate at 2^32-1.
REQ-032 Without BATCH_SCHED_STATS_EN, the stat ports SHALL remain present, tied to 0, with no counter logic.

Structure
REQ-033 The shared package SHALL hold the state enum (IDLE/DRAIN/CLOSE), the SIZE_W default and the READ_LATENCY default, shared with the batch FIFO and permuter wrappers.
REQ-034 A single sub-module, rr_grant_picker, SHALL take the request vector and lastGrant and return the grant index plus a found flag, combinationally.
REQ-035 The delay pipes SHALL use the existing hyperpipe block.

Verification
REQ-036 Scenario: reset, then batchValid=0b00000001 with size 3 -> accept[0] at cycle 1; readReq[0] for 3 cycles; dataArrives 3 pulses READ_LATENCY later; then batchDoneArrives 1 pulse; statItems=3 if the macro is enabled.
REQ-037 Scenario: all 8 valid, sizes 1 -> grant order 0,1,...,7, then wraps to 0 if still valid.
REQ-038 Scenario: size 0 on requester 5 -> accept[5]; no readReq; batchDoneArrives READ_LATENCY+1 cycles after accept.
REQ-039 Scenario: size 4 with slowDown high for 2 cycles mid-drain -> exactly 4 readReq pulses; remaining holds during the stall; statStalls=2.
REQ-040 Scenario: size 63 -> 63 reads and 1 end marker; no underflow.
REQ-041 Scenario: rst asserted after 2 of 5 reads -> readReq and batchDoneArrives stay 0 thereafter; next grant goes to index 0.
